// File: rtl/reg_file_sb.sv
// Scoreboarded register file: two combinational read ports, one write port, per-register busy bits.
// Define REG_FILE_BYPASS_EN to forward same-cycle writeback data and busy state to the read ports.
module reg_file_sb #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
) (
   input  logic              clk0,
   input  logic              rst0,
   input  logic [ADDR_W-1:0] a_addr,
   output logic [DATA_W-1:0] a_data,
   output logic              a_busy,
   input  logic [ADDR_W-1:0] b_addr,
   output logic [DATA_W-1:0] b_data,
   output logic              b_busy,
   input  logic              w_en,
   input  logic [ADDR_W-1:0] w_addr,
   input  logic [DATA_W-1:0] w_data,
   input  logic              iss_en,
   input  logic [ADDR_W-1:0] iss_addr,
   output logic [ADDR_W:0]   busy_cnt,
   output logic              iss_err
);

   localparam int unsigned      DEPTH   = 2 ** ADDR_W;
   localparam logic [ADDR_W:0]  CNT_ONE = 1;

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DEPTH-1:0]  busy_q, busy_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic              err_q, err_d;
   logic              w_v, i_v, inc, dec;

   // Register 0 is never written or reserved, so its zero value falls out of the gating below.
   always_comb begin
      w_v    = w_en && (w_addr != '0);
      i_v    = iss_en && (iss_addr != '0);
      busy_d = busy_q;
      if (w_v) busy_d[w_addr] = 1'b0;
      if (i_v) busy_d[iss_addr] = 1'b1;
      inc    = i_v && !busy_q[iss_addr];
      dec    = w_v && busy_q[w_addr] && !(i_v && (iss_addr == w_addr));
      cnt_d  = cnt_q;
      if (inc && !dec)      cnt_d = cnt_q + CNT_ONE;
      else if (dec && !inc) cnt_d = cnt_q - CNT_ONE;
      err_d  = i_v && busy_q[iss_addr] && !(w_v && (w_addr == iss_addr));
   end

   always_ff @(posedge clk0) begin
      if (rst0) begin
         regs_q <= '{default: '0};
         busy_q <= '0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         if (w_v) regs_q[w_addr] <= w_data;
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         err_q  <= err_d;
      end
   end

   always_comb begin
      a_data = regs_q[a_addr];
      a_busy = busy_q[a_addr];
      b_data = regs_q[b_addr];
      b_busy = busy_q[b_addr];
`ifdef REG_FILE_BYPASS_EN
      // A forwarded port's busy reflects only the same-cycle reservation, since the write clears it.
      if (w_v && (w_addr == a_addr)) begin
         a_data = w_data;
         a_busy = i_v && (iss_addr == a_addr);
      end
      if (w_v && (w_addr == b_addr)) begin
         b_data = w_data;
         b_busy = i_v && (iss_addr == b_addr);
      end
`endif
   end

   assign busy_cnt = cnt_q;
   assign iss_err  = err_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed self-checking bench for reg_file_sb; expectations follow REG_FILE_BYPASS_EN if defined.
module tb_reg_file_sb;

   logic        clk0 = 1'b0;
   logic        rst0;
   logic [2:0]  a_addr, b_addr, w_addr, iss_addr;
   logic [15:0] a_data, b_data, w_data;
   logic        a_busy, b_busy, w_en, iss_en, iss_err;
   logic [3:0]  busy_cnt;

   int passed = 0;
   int total  = 0;

   reg_file_sb #(.DATA_W(16), .ADDR_W(3)) dut (
      .clk0(clk0), .rst0(rst0),
      .a_addr(a_addr), .a_data(a_data), .a_busy(a_busy),
      .b_addr(b_addr), .b_data(b_data), .b_busy(b_busy),
      .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
      .iss_en(iss_en), .iss_addr(iss_addr),
      .busy_cnt(busy_cnt), .iss_err(iss_err)
   );

   always #5 clk0 = ~clk0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk0);
      #1;
   endtask

   initial begin
      logic bypass;
`ifdef REG_FILE_BYPASS_EN
      bypass = 1'b1;
`else
      bypass = 1'b0;
`endif
      rst0 = 1'b1; w_en = 1'b0; iss_en = 1'b0;
      a_addr = '0; b_addr = '0; w_addr = '0; iss_addr = '0; w_data = '0;
      tick(); tick();
      rst0 = 1'b0;

      // reset state on every address, both ports
      for (int i = 0; i < 8; i++) begin
         a_addr = i[2:0]; b_addr = 3'(7 - i);
         #1;
         chk("rst_a_data", 32'(a_data), 32'h0);
         chk("rst_b_data", 32'(b_data), 32'h0);
         chk("rst_a_busy", 32'(a_busy), 32'h0);
         chk("rst_b_busy", 32'(b_busy), 32'h0);
      end
      chk("rst_cnt", 32'(busy_cnt), 32'h0);
      chk("rst_err", 32'(iss_err), 32'h0);

      // write r3, attempt write to r0
      w_en = 1'b1; w_addr = 3'd3; w_data = 16'hBEEF;
      tick();
      w_addr = 3'd0; w_data = 16'h1234;
      tick();
      w_en = 1'b0; a_addr = 3'd3; b_addr = 3'd0;
      #1;
      chk("wr_r3", 32'(a_data), 32'hBEEF);
      chk("wr_r0_ignored", 32'(b_data), 32'h0);

      // reserve r5, then re-issue it
      iss_en = 1'b1; iss_addr = 3'd5;
      tick();
      a_addr = 3'd5;
      #1;
      chk("iss5_busy", 32'(a_busy), 32'h1);
      chk("iss5_cnt", 32'(busy_cnt), 32'h1);
      chk("iss5_err", 32'(iss_err), 32'h0);
      tick();
      iss_en = 1'b0;
      #1;
      chk("reiss5_err", 32'(iss_err), 32'h1);
      chk("reiss5_cnt", 32'(busy_cnt), 32'h1);
      chk("reiss5_busy", 32'(a_busy), 32'h1);
      tick();
      chk("reiss5_err_pulse", 32'(iss_err), 32'h0);
      w_en = 1'b1; w_addr = 3'd5; w_data = 16'h00AA;
      tick();
      w_en = 1'b0;
      #1;
      chk("wb5_busy", 32'(a_busy), 32'h0);
      chk("wb5_cnt", 32'(busy_cnt), 32'h0);
      chk("wb5_data", 32'(a_data), 32'h00AA);

      // issues to r0 are ignored and never error
      iss_en = 1'b1; iss_addr = 3'd0;
      tick(); tick();
      iss_en = 1'b0; a_addr = 3'd0;
      #1;
      chk("iss0_err", 32'(iss_err), 32'h0);
      chk("iss0_cnt", 32'(busy_cnt), 32'h0);
      chk("iss0_busy", 32'(a_busy), 32'h0);

      // r2 busy, then write and re-issue r2 together
      iss_en = 1'b1; iss_addr = 3'd2;
      tick();
      chk("iss2_cnt", 32'(busy_cnt), 32'h1);
      w_en = 1'b1; w_addr = 3'd2; w_data = 16'h5555;
      tick();
      w_en = 1'b0; iss_en = 1'b0; b_addr = 3'd2;
      #1;
      chk("wi2_busy", 32'(b_busy), 32'h1);
      chk("wi2_cnt", 32'(busy_cnt), 32'h1);
      chk("wi2_err", 32'(iss_err), 32'h0);
      chk("wi2_data", 32'(b_data), 32'h5555);

      // same-cycle read of r4 while writing it
      a_addr = 3'd4; w_en = 1'b1; w_addr = 3'd4; w_data = 16'hCAFE;
      #1;
      chk("byp4_data", 32'(a_data), bypass ? 32'hCAFE : 32'h0);
      chk("byp4_busy", 32'(a_busy), 32'h0);
      tick();
      w_en = 1'b0;
      #1;
      chk("wr4_data", 32'(a_data), 32'hCAFE);

      // write and issue r6 together (r6 idle): forwarded busy reads 1
      a_addr = 3'd6; w_en = 1'b1; w_addr = 3'd6; w_data = 16'h6666;
      iss_en = 1'b1; iss_addr = 3'd6;
      #1;
      chk("byp6_busy", 32'(a_busy), 32'h1 & 32'(bypass));
      chk("byp6_data", 32'(a_data), bypass ? 32'h6666 : 32'h0);
      tick();
      iss_en = 1'b0; w_data = 16'h0606;
      #1;
      chk("wi6_cnt", 32'(busy_cnt), 32'h2);
      chk("wi6_busy", 32'(a_busy), bypass ? 32'h0 : 32'h1);
      // release r6 then r2
      tick();
      w_addr = 3'd2; w_data = 16'h2222;
      tick();
      w_en = 1'b0;
      #1;
      chk("rel_cnt", 32'(busy_cnt), 32'h0);
      chk("rel_r6", 32'(a_data), 32'h0606);

      // fill the scoreboard r1..r7
      iss_en = 1'b1;
      for (int i = 1; i < 8; i++) begin
         iss_addr = i[2:0];
         tick();
         chk("fill_cnt", 32'(busy_cnt), 32'(i));
         chk("fill_err", 32'(iss_err), 32'h0);
      end
      iss_en = 1'b0; a_addr = 3'd7; b_addr = 3'd1;
      #1;
      chk("full_busy_a", 32'(a_busy), 32'h1);
      chk("full_busy_b", 32'(b_busy), 32'h1);

      // reset beats a simultaneous write and issue
      rst0 = 1'b1; w_en = 1'b1; w_addr = 3'd1; w_data = 16'hFFFF;
      iss_en = 1'b1; iss_addr = 3'd1;
      tick();
      rst0 = 1'b0; w_en = 1'b0; iss_en = 1'b0;
      a_addr = 3'd1; b_addr = 3'd3;
      #1;
      chk("rst2_r1", 32'(a_data), 32'h0);
      chk("rst2_r1_busy", 32'(a_busy), 32'h0);
      chk("rst2_r3", 32'(b_data), 32'h0);
      chk("rst2_cnt", 32'(busy_cnt), 32'h0);
      chk("rst2_err", 32'(iss_err), 32'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised, scoreboarded general-purpose register file for the CPU datapath, sitting between decode/issue and writeback. It provides two asynchronous read ports and one synchronous write port, with register 0 hardwired to zero. A per-register busy scoreboard lets issue logic reserve a destination register and detect read-after-write hazards until writeback clears the reservation.

## Interface
Parameters:
- DATA_W, 16, register width in bits
- ADDR_W, 3, address width; depth = 2**ADDR_W registers

Ports:
- clk0  input  1  clock; all state updates on rising edge
- rst0  input  1  reset, synchronous, active-high
- a_addr  input  ADDR_W  read port A address
- a_data  output  DATA_W  read port A data
- a_busy  output  1  read port A register reserved
- b_addr  input  ADDR_W  read port B address
- b_data  output  DATA_W  read port B data
- b_busy  output  1  read port B register reserved
- w_en  input  1  writeback strobe
- w_addr  input  ADDR_W  writeback address
- w_data  input  DATA_W  writeback data
- iss_en  input  1  reserve destination register
- iss_addr  input  ADDR_W  register to reserve
- busy_cnt  output  ADDR_W+1  number of reserved registers
- iss_err  output  1  registered one-cycle pulse: issue to an already-reserved register

## Operation
- Storage: 2**ADDR_W × DATA_W registers and 2**ADDR_W busy bits.
- Register 0:
  - reads always 0 and its busy bit is always 0;
  - writes and issues to address 0 are ignored;
  - an issue to address 0 never raises iss_err.
- Read: a_data = regs[a_addr] and b_data = regs[b_addr], combinational. a_busy and b_busy = busy[addr], combinational. Both ports are fully independent and may use the same address.
- Write: if w_en and w_addr≠0, then regs[w_addr] ← w_data and busy[w_addr] ← 0. Writing a register that is not busy is legal; the data is stored and busy stays 0.
- Issue: if iss_en and iss_addr≠0, then busy[iss_addr] ← 1.
- Write and issue to the same address in the same cycle: data is written and busy ends at 1 (set wins; the new reservation follows the old writeback).
- iss_err: asserted for one cycle, in the cycle after an issue to a nonzero address whose busy bit was 1 and which was not being written that same cycle. The busy bit stays 1 in that case.
- busy_cnt: registered population count of the busy bits, updated incrementally.
  - +1 for an issue that sets a clear bit;
  - −1 for a write that clears a set bit not re-issued that cycle;
  - net 0 when both happen.
  - Range 0 to 2**ADDR_W−1; it never wraps.
- Reset (rst0=1 at a clock edge) has priority over everything, including a simultaneous write or issue. It sets all registers to 0, all busy bits to 0, busy_cnt to 0 and iss_err to 0.
- Output values after reset: a_data=b_data=0, a_busy=b_busy=0, busy_cnt=0, iss_err=0.

## Timing
- Read latency: 0 cycles (combinational from address and stored state).
- A write at edge N is visible on the read ports after edge N; without bypass, a read in the same cycle returns the old value.
- A busy set or clear at edge N is visible on a_busy/b_busy and busy_cnt after edge N.
- iss_err is high during cycle N+1 only, for an offending issue sampled at edge N.
- No handshake stalls: w_en and iss_en are accepted every cycle.

## Configuration
- REG_FILE_BYPASS_EN defined: write-to-read forwarding is enabled.
  - When w_en=1 and w_addr≠0 matches a read address, that port returns w_data in the same cycle.
  - That port's busy output reads 0, unless iss_en targets the same address in the same cycle, in which case it reads 1.
- REG_FILE_BYPASS_EN undefined: the read ports reflect stored state only; the new value appears the cycle after the write.
- Reset, register-0 rules and scoreboard semantics are identical in both builds.

## Test plan
- Reset then read all addresses on both ports → data 0, busy 0, busy_cnt 0, iss_err 0.
- Write 0xBEEF to r3 and 0x1234 to r0, then read a=3, b=0 the next cycle → a_data 0xBEEF, b_data 0x0000.
- Issue r5 → a_busy(5)=1 and busy_cnt=1 next cycle. Issue r5 again → iss_err pulses for one cycle and busy_cnt stays 1. Write r5=0x00AA → busy 0, busy_cnt 0.
- Same cycle: write r2=0x5555 and issue r2, with r2 previously busy → busy stays 1, busy_cnt unchanged, iss_err 0, and r2 reads 0x5555 next cycle.
- Read r4 while writing r4=0xCAFE: with REG_FILE_BYPASS_EN → a_data 0xCAFE and a_busy 0 in that cycle; without it → the old value, with 0xCAFE the next cycle.
- Issue r1..r7 on consecutive cycles → busy_cnt reaches 7. Assert rst0 together with a write to r1 → all state 0, and r1 reads 0.
